// File: rtl/foodfight_adc_if.sv
// CPU-side bus of the Food Fight stick ADC: conversion request in, result and status out.
// The master is the CPU I/O decode and the slave is the ADC.
interface foodfight_adc_if;
  logic       START;
  logic [1:0] CH;
  logic [7:0] DOUT;
  logic [1:0] DCH;
  logic       EOC;

  modport master (
    output START,
    output CH,
    input  DOUT,
    input  DCH,
    input  EOC
  );

  modport slave (
    input  START,
    input  CH,
    output DOUT,
    output DCH,
    output EOC
  );
endinterface

// File: rtl/foodfight_adc.sv
// Multiplexed 8-bit stick ADC for the Food Fight core. It samples and holds one of the four
// stick positions, counts CEN ticks for the conversion, then presents the result with EOC.
module foodfight_adc #(
  parameter int unsigned CONV_TICKS = 64
) (
  input  logic            MCLK,
  input  logic            RESET,
  input  logic            CEN,
  input  logic [7:0]      AX0,
  input  logic [7:0]      AY0,
  input  logic [7:0]      AX1,
  input  logic [7:0]      AY1,
  foodfight_adc_if.slave  cpu
);

  typedef enum logic [1:0] {StIdle, StSample, StConvert} state_e;

  localparam logic [7:0] CntInit = 8'(CONV_TICKS - 1);

  state_e     state_q, state_d;
  logic [1:0] pend_ch_q, pend_ch_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic [1:0] dch_q, dch_d;
  logic       eoc_q, eoc_d;
  logic [7:0] stick_sel;

  always_comb begin
    unique case (pend_ch_q)
      2'd0:    stick_sel = AX0;
      2'd1:    stick_sel = AY0;
      2'd2:    stick_sel = AX1;
      default: stick_sel = AY1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pend_ch_d = pend_ch_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dch_d     = dch_q;
    eoc_d     = eoc_q;
    // A new request pre-empts whatever the CEN tick would have done in this cycle.
    if (cpu.START) begin
      pend_ch_d = cpu.CH;
      state_d   = StSample;
      eoc_d     = 1'b0;
    end else if (CEN) begin
      unique case (state_q)
        StSample: begin
          hold_d  = stick_sel;
          cnt_d   = CntInit;
          state_d = StConvert;
        end
        StConvert: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            dout_d  = hold_q;
            dch_d   = pend_ch_q;
            eoc_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      pend_ch_q <= 2'd0;
      hold_q    <= 8'h00;
      cnt_q     <= 8'd0;
      dout_q    <= 8'h00;
      dch_q     <= 2'd0;
      eoc_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      pend_ch_q <= pend_ch_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dch_q     <= dch_d;
      eoc_q     <= eoc_d;
    end
  end

  assign cpu.DOUT = dout_q;
  assign cpu.DCH  = dch_q;
  assign cpu.EOC  = eoc_q;

endmodule
